loader_bus_sched: RTL and testbench

- Schedules the single main-RAM write port between the Z80 CPU bus and the cmd_loader output stream.
- Buffers loader writes in a small FIFO and holds the CPU for the whole download.
- Back-pressures ioctl through the loader wait path.
- After download completes and the FIFO drains, hands the loader's execute address to the CPU jump logic with a req/ack handshake.

---
 rtl/loader_pkg.sv | 17 +
 rtl/ldr_wr_fifo.sv | 75 +++++++
 rtl/loader_bus_sched.sv | 165 ++++++++++++++++
 tb/tb_loader_bus_sched.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the loader / CPU RAM-port scheduler.
package loader_pkg;

    // Who currently owns the main-RAM write port, and the handoff phases.
    typedef enum logic [1:0] {
        S_CPU   = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_EXEC  = 2'd3
    } sched_state_t;

    localparam int LDR_ADDR_W = 16;
    localparam int LDR_DATA_W = 8;
    // One FIFO entry is {addr, data}, address in the upper bits.
    localparam int FIFO_W     = LDR_ADDR_W + LDR_DATA_W;

endpackage

// File: rtl/ldr_wr_fifo.sv
// Small synchronous FIFO for buffered loader writes.
// A push while full is dropped and reported on ovf for one cycle, even if a
// pop happens in the same cycle. A pop while empty is ignored.
module ldr_wr_fifo
    import loader_pkg::*;
#(
    parameter int W     = FIFO_W,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign ovf     = push & full;

    // Pointer, count and storage updates; pointers wrap modulo DEPTH.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Register state; storage contents need no reset.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/loader_bus_sched.sv
// Arbitrates the single main-RAM write port between the Z80 bus and the
// cmd_loader stream, holds the CPU during a download, and hands the execute
// address to the CPU jump logic once every buffered write has landed.
module loader_bus_sched
    import loader_pkg::*;
#(
    parameter int DATA  = 8,
    parameter int ADDR  = 16,
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ldr_download,
    input  logic            ldr_wr,
    input  logic [ADDR-1:0] ldr_addr,
    input  logic [DATA-1:0] ldr_data,
    input  logic            ldr_exec_en,
    input  logic [ADDR-1:0] ldr_exec_addr,
    output logic            ldr_wait,
    input  logic            cpu_req,
    input  logic [ADDR-1:0] cpu_addr,
    input  logic [DATA-1:0] cpu_wdata,
    output logic            cpu_wait,
    output logic            cpu_hold,
    input  logic            ram_busy,
    output logic            ram_we,
    output logic [ADDR-1:0] ram_addr,
    output logic [DATA-1:0] ram_wdata,
    output logic            exec_req,
    output logic [ADDR-1:0] exec_addr,
    input  logic            exec_ack,
    output logic            ovf_err
);

    localparam int FW = ADDR + DATA;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] WAIT_LVL = CW'(DEPTH - 1);

    sched_state_t    state_q, state_d;
    logic            prev_dl_q, prev_dl_d;
    logic            exec_pending_q, exec_pending_d;
    logic            exec_req_q, exec_req_d;
    logic [ADDR-1:0] exec_addr_q, exec_addr_d;
    logic            ovf_q, ovf_d;

    logic [FW-1:0]   fifo_head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_ovf;
    logic            pop;
    logic            dl_rise;
    logic            drained;

    ldr_wr_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (ldr_wr),
        .din   ({ldr_addr, ldr_data}),
        .pop   (pop),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty),
        .ovf   (fifo_ovf)
    );

    assign dl_rise   = ldr_download & ~prev_dl_q;
    assign pop       = ((state_q == S_LOAD) || (state_q == S_FLUSH)) & ~fifo_empty & ~ram_busy;
    // FIFO is empty after this cycle, counting a pop that takes the last entry.
    assign drained   = fifo_empty || ((fifo_count == CW'(1)) && pop);
    assign ldr_wait  = (fifo_count >= WAIT_LVL);
    assign cpu_hold  = (state_q != S_CPU);
    assign cpu_wait  = cpu_req & ((state_q != S_CPU) | ram_busy);
    assign exec_req  = exec_req_q;
    assign exec_addr = exec_addr_q;
    assign ovf_err   = ovf_q;

    // RAM port mux: loader FIFO head on a pop, else an eligible CPU write.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (pop) begin
            ram_we    = 1'b1;
            ram_addr  = fifo_head[FW-1:DATA];
            ram_wdata = fifo_head[DATA-1:0];
        end else if ((state_q == S_CPU) && cpu_req && !ram_busy) begin
            ram_we    = 1'b1;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end
    end

    // Next state, execute bookkeeping and sticky overflow.
    always_comb begin
        state_d        = state_q;
        prev_dl_d      = ldr_download;
        exec_pending_d = exec_pending_q;
        exec_req_d     = exec_req_q;
        exec_addr_d    = exec_addr_q;
        ovf_d          = ovf_q | fifo_ovf;
        case (state_q)
            S_CPU: begin
                if (dl_rise) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (ldr_exec_en) begin
                    exec_pending_d = 1'b1;
                    exec_addr_d    = ldr_exec_addr;
                end
                // Covers both normal end of download and abort.
                if (!ldr_download) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (dl_rise) begin
                    state_d = S_LOAD;
                end else if (drained) begin
                    if (exec_pending_q) begin
                        state_d    = S_EXEC;
                        exec_req_d = 1'b1;
                    end else begin
                        state_d = S_CPU;
                    end
                end
            end
            S_EXEC: begin
                // A new download supersedes the pending jump.
                if (dl_rise) begin
                    state_d        = S_LOAD;
                    exec_req_d     = 1'b0;
                    exec_pending_d = 1'b0;
                end else if (exec_ack) begin
                    state_d        = S_CPU;
                    exec_req_d     = 1'b0;
                    exec_pending_d = 1'b0;
                end
            end
            default: state_d = S_CPU;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_CPU;
            prev_dl_q      <= 1'b0;
            exec_pending_q <= 1'b0;
            exec_req_q     <= 1'b0;
            exec_addr_q    <= '0;
            ovf_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            prev_dl_q      <= prev_dl_d;
            exec_pending_q <= exec_pending_d;
            exec_req_q     <= exec_req_d;
            exec_addr_q    <= exec_addr_d;
            ovf_q          <= ovf_d;
        end
    end

endmodule

// File: tb/tb_loader_bus_sched.sv
// Directed bench for loader_bus_sched. Inputs change on the falling edge;
// outputs are sampled 1 time unit later, before the next rising edge.
module tb_loader_bus_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        ldr_download;
    logic        ldr_wr;
    logic [15:0] ldr_addr;
    logic [7:0]  ldr_data;
    logic        ldr_exec_en;
    logic [15:0] ldr_exec_addr;
    logic        ldr_wait;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_wait;
    logic        cpu_hold;
    logic        ram_busy;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        exec_req;
    logic [15:0] exec_addr;
    logic        exec_ack;
    logic        ovf_err;

    int n_tests = 0;
    int n_fail  = 0;

    loader_bus_sched #(.DATA(8), .ADDR(16), .DEPTH(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .ldr_download  (ldr_download),
        .ldr_wr        (ldr_wr),
        .ldr_addr      (ldr_addr),
        .ldr_data      (ldr_data),
        .ldr_exec_en   (ldr_exec_en),
        .ldr_exec_addr (ldr_exec_addr),
        .ldr_wait      (ldr_wait),
        .cpu_req       (cpu_req),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_wait      (cpu_wait),
        .cpu_hold      (cpu_hold),
        .ram_busy      (ram_busy),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .exec_req      (exec_req),
        .exec_addr     (exec_addr),
        .exec_ack      (exec_ack),
        .ovf_err       (ovf_err)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic idle_inputs();
        ldr_download  = 1'b0;
        ldr_wr        = 1'b0;
        ldr_addr      = '0;
        ldr_data      = '0;
        ldr_exec_en   = 1'b0;
        ldr_exec_addr = '0;
        cpu_req       = 1'b0;
        cpu_addr      = '0;
        cpu_wdata     = '0;
        ram_busy      = 1'b0;
        exec_ack      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_tests++;
        if ({ram_we, cpu_hold, ldr_wait, ovf_err, exec_req, cpu_wait} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: we/hold/wait/ovf/req/cwait=%b expected 000000",
                     {ram_we, cpu_hold, ldr_wait, ovf_err, exec_req, cpu_wait});
        end
        n_tests++;
        if (exec_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_exec_addr: got %h expected 0000", exec_addr);
        end
        @(negedge clock);
    endtask

    task automatic test_load_basic();
        logic [15:0] wa [3];
        logic [7:0]  wd [3];
        wa[0] = 16'h5200; wa[1] = 16'h5201; wa[2] = 16'h5202;
        wd[0] = 8'h11;    wd[1] = 8'h22;    wd[2] = 8'h33;
        ldr_download = 1'b1;
        #1;
        n_tests++;
        if (cpu_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_hold_rise: cpu_hold=%b expected 0", cpu_hold);
        end
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            ldr_wr    = (i < 3);
            ldr_addr  = (i < 3) ? wa[i] : 16'h0;
            ldr_data  = (i < 3) ? wd[i] : 8'h0;
            cpu_req   = 1'b1;
            cpu_addr  = 16'h1234;
            cpu_wdata = 8'hEE;
            #1;
            if (i >= 1 && i <= 3) begin
                n_tests++;
                if ({ram_we, ram_addr, ram_wdata} !== {1'b1, wa[i-1], wd[i-1]}) begin
                    n_fail++;
                    $display("FAIL basic_write%0d: we/addr/data=%b/%h/%h expected 1/%h/%h",
                             i - 1, ram_we, ram_addr, ram_wdata, wa[i-1], wd[i-1]);
                end
            end else begin
                n_tests++;
                if (ram_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_idle%0d: ram_we=%b expected 0", i, ram_we);
                end
            end
            n_tests++;
            if ({cpu_hold, cpu_wait} !== 2'b11) begin
                n_fail++;
                $display("FAIL basic_cpu_stall%0d: hold/wait=%b expected 11", i, {cpu_hold, cpu_wait});
            end
            @(negedge clock);
        end
        ldr_wr = 1'b0; cpu_req = 1'b0; ldr_download = 1'b0;
        #1;
        @(negedge clock);
        #1;
        n_tests++;
        if (cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_flush_hold: cpu_hold=%b expected 1", cpu_hold);
        end
        @(negedge clock);
        #1;
        n_tests++;
        if ({cpu_hold, exec_req} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_release: hold/req=%b expected 00", {cpu_hold, exec_req});
        end
        @(negedge clock);
    endtask

    task automatic test_overflow();
        ldr_download = 1'b1;
        ram_busy     = 1'b1;
        #1;
        @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            ldr_wr   = 1'b1;
            ldr_addr = 16'h5200 + 16'(i);
            ldr_data = 8'hA0 + 8'(i);
            ram_busy = 1'b1;
            #1;
            n_tests++;
            if ({ldr_wait, ram_we, ovf_err} !== {(i >= 3), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL ovf_fill%0d: wait/we/ovf=%b expected %b00",
                         i, {ldr_wait, ram_we, ovf_err}, (i >= 3));
            end
            @(negedge clock);
        end
        for (int j = 0; j < 4; j++) begin
            ldr_wr   = 1'b0;
            ram_busy = 1'b0;
            #1;
            n_tests++;
            if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 16'h5200 + 16'(j), 8'hA0 + 8'(j)}) begin
                n_fail++;
                $display("FAIL ovf_drain%0d: we/addr/data=%b/%h/%h expected 1/%h/%h",
                         j, ram_we, ram_addr, ram_wdata, 16'h5200 + 16'(j), 8'hA0 + 8'(j));
            end
            n_tests++;
            if ({ldr_wait, ovf_err} !== {(j < 2), 1'b1}) begin
                n_fail++;
                $display("FAIL ovf_flags%0d: wait/ovf=%b expected %b1", j, {ldr_wait, ovf_err}, (j < 2));
            end
            @(negedge clock);
        end
        ldr_download = 1'b0;
        #1;
        n_tests++;
        if (ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_no_5204: ram_we=%b addr=%h expected we 0", ram_we, ram_addr);
        end
        @(negedge clock);
        @(negedge clock);
        #1;
        n_tests++;
        if ({cpu_hold, ovf_err} !== 2'b01) begin
            n_fail++;
            $display("FAIL ovf_sticky: hold/ovf=%b expected 01", {cpu_hold, ovf_err});
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_tests++;
        if (ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_cleared: ovf_err=%b expected 0", ovf_err);
        end
        @(negedge clock);
    endtask

    task automatic test_exec();
        ldr_download = 1'b1;
        ram_busy     = 1'b1;
        @(negedge clock);
        ldr_exec_en = 1'b1; ldr_exec_addr = 16'h1111;
        ldr_wr = 1'b1; ldr_addr = 16'h5300; ldr_data = 8'h55;
        @(negedge clock);
        ldr_exec_en = 1'b1; ldr_exec_addr = 16'h5200;
        ldr_wr = 1'b1; ldr_addr = 16'h5301; ldr_data = 8'h66;
        @(negedge clock);
        ldr_exec_en = 1'b0; ldr_wr = 1'b0; ldr_download = 1'b0;
        #1;
        n_tests++;
        if (ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL exec_busy_hold: ram_we=%b expected 0", ram_we);
        end
        @(negedge clock);
        ram_busy = 1'b0;
        #1;
        n_tests++;
        if ({ram_we, ram_addr, ram_wdata, exec_req} !== {1'b1, 16'h5300, 8'h55, 1'b0}) begin
            n_fail++;
            $display("FAIL exec_flush0: we/addr/data/req=%b/%h/%h/%b expected 1/5300/55/0",
                     ram_we, ram_addr, ram_wdata, exec_req);
        end
        @(negedge clock);
        #1;
        n_tests++;
        if ({ram_we, ram_addr, ram_wdata, exec_req} !== {1'b1, 16'h5301, 8'h66, 1'b0}) begin
            n_fail++;
            $display("FAIL exec_flush1: we/addr/data/req=%b/%h/%h/%b expected 1/5301/66/0",
                     ram_we, ram_addr, ram_wdata, exec_req);
        end
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            exec_ack = (k == 2);
            #1;
            n_tests++;
            if ({exec_req, exec_addr, cpu_hold, ram_we} !== {1'b1, 16'h5200, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL exec_req%0d: req/addr/hold/we=%b/%h/%b/%b expected 1/5200/1/0",
                         k, exec_req, exec_addr, cpu_hold, ram_we);
            end
            @(negedge clock);
        end
        exec_ack = 1'b0;
        #1;
        n_tests++;
        if ({exec_req, cpu_hold} !== 2'b00) begin
            n_fail++;
            $display("FAIL exec_done: req/hold=%b expected 00", {exec_req, cpu_hold});
        end
        @(negedge clock);
    endtask

    task automatic test_abort();
        ldr_download = 1'b1;
        ram_busy     = 1'b1;
        @(negedge clock);
        ldr_wr = 1'b1; ldr_addr = 16'h5400; ldr_data = 8'h77;
        @(negedge clock);
        ldr_wr = 1'b0; ldr_download = 1'b0;
        #1;
        n_tests++;
        if (ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: ram_we=%b expected 0", ram_we);
        end
        @(negedge clock);
        ram_busy = 1'b0;
        ldr_exec_en = 1'b1; ldr_exec_addr = 16'h4444;
        #1;
        n_tests++;
        if ({ram_we, ram_addr, ram_wdata, cpu_hold} !== {1'b1, 16'h5400, 8'h77, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_flush: we/addr/data/hold=%b/%h/%h/%b expected 1/5400/77/1",
                     ram_we, ram_addr, ram_wdata, cpu_hold);
        end
        @(negedge clock);
        ldr_exec_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_tests++;
            if ({cpu_hold, exec_req, exec_addr} !== {1'b0, 1'b0, 16'h5200}) begin
                n_fail++;
                $display("FAIL abort_no_exec%0d: hold/req/addr=%b/%b/%h expected 0/0/5200",
                         k, cpu_hold, exec_req, exec_addr);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset_mid_load();
        ldr_download = 1'b1;
        ram_busy     = 1'b1;
        @(negedge clock);
        ldr_wr = 1'b1; ldr_addr = 16'h5500; ldr_data = 8'h88;
        @(negedge clock);
        ldr_wr = 1'b1; ldr_addr = 16'h5501; ldr_data = 8'h99;
        @(negedge clock);
        ldr_wr = 1'b0;
        reset  = 1'b1;
        @(negedge clock);
        reset = 1'b0; ldr_download = 1'b0; ram_busy = 1'b0;
        #1;
        n_tests++;
        if ({ram_we, cpu_hold, ldr_wait, ovf_err, exec_req} !== 5'b0) begin
            n_fail++;
            $display("FAIL rstmid_flags: we/hold/wait/ovf/req=%b expected 00000",
                     {ram_we, cpu_hold, ldr_wait, ovf_err, exec_req});
        end
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (ram_we !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_discard%0d: ram_we=%b addr=%h expected we 0", k, ram_we, ram_addr);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_cpu_write();
        logic busy_seq [3];
        busy_seq[0] = 1'b1; busy_seq[1] = 1'b1; busy_seq[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cpu_req   = 1'b1;
            cpu_addr  = 16'h3C00;
            cpu_wdata = 8'h41;
            ram_busy  = busy_seq[k];
            #1;
            n_tests++;
            if ({cpu_wait, ram_we, cpu_hold} !== {busy_seq[k], ~busy_seq[k], 1'b0}) begin
                n_fail++;
                $display("FAIL cpu_arb%0d: wait/we/hold=%b expected %b%b0",
                         k, {cpu_wait, ram_we, cpu_hold}, busy_seq[k], ~busy_seq[k]);
            end
            if (!busy_seq[k]) begin
                n_tests++;
                if ({ram_addr, ram_wdata} !== {16'h3C00, 8'h41}) begin
                    n_fail++;
                    $display("FAIL cpu_data: addr/data=%h/%h expected 3c00/41", ram_addr, ram_wdata);
                end
            end
            @(negedge clock);
        end
        cpu_req  = 1'b0;
        ram_busy = 1'b0;
        #1;
        n_tests++;
        if ({ram_we, cpu_wait} !== 2'b00) begin
            n_fail++;
            $display("FAIL cpu_idle: we/wait=%b expected 00", {ram_we, cpu_wait});
        end
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(negedge clock);
        test_reset();
        test_load_basic();
        test_overflow();
        test_exec();
        test_abort();
        test_reset_mid_load();
        test_cpu_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
